huffman_decoder: RTL and testbench
==================================

# huffman_decoder

Serial Huffman decoder for the grey-level image path. It is the receive-side counterpart of the `huffman` encoder. It loads the six-entry code table (HC1–HC6 codes, M1–M6 length masks) on `code_valid`, then accepts a bit-serial stream one bit per handshake and emits the decoded grey level (1–6) per codeword. After `NUM_SYMS` symbols it stops and reports done. Illegal streams stop it with a sticky error.

## Interface
- `NUM_SYMS`, default 100: symbols decoded before `done`; legal range 1–255.
- `MAX_LEN`, default 8: longest legal codeword in bits; legal range 1–8.

Ports:
- `clk` input 1: clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low reset. Sampled on the rising edge of `clk`; low clears all state.
- `code_valid` input 1: table load strobe. Only honoured in IDLE.
- `HC1`..`HC6` input 8 each: codeword for symbols 1..6, right-aligned. Bit[len-1] is transmitted first.
- `M1`..`M6` input 8 each: length mask, contiguous low-order ones; popcount = code length. 8'h00 = symbol unused.
- `bit_valid` input 1: `bit_in` is valid.
- `bit_in` input 1: stream bit.
- `bit_ready` output 1: decoder accepts a bit this cycle.
- `sym_valid` output 1: one-cycle pulse, `sym` valid.
- `sym` output 3: decoded symbol, 1..6.
- `done` output 1: `NUM_SYMS` symbols emitted; sticky.
- `err` output 1: illegal codeword detected; sticky.
- `CNT1`..`CNT6` output 8 each: per-symbol decoded counts. Present only with `HUFF_DEC_HIST_EN`.

## Operation
- States: IDLE, DECODE, ERROR, DONE.
- IDLE:
  - `bit_ready`=0.
  - `code_valid`=1 registers all HC/M and moves to DECODE.
  - Each stored length is computed as popcount(M) (4 bits).
- DECODE:
  - `bit_ready`=1.
  - Bit accepted when `bit_valid`&&`bit_ready`.
  - Shift register `acc` (8 bits) takes `{acc[6:0],bit_in}`; length counter `len` (4 bits) increments.
  - Match on the post-shift value: entry k matches when M_k≠0, len_k==len+1, and (new_acc & M_k)==HC_k. Compare against the new value, not the registered one.
  - Table is assumed prefix-free. If several entries match, the lowest index wins.
  - On match: `sym`←k, `sym_valid` pulses, `acc` and `len` cleared, symbol counter (8 bits) increments.
  - If the counter reaches `NUM_SYMS`, go to DONE.
  - On no match with len+1==`MAX_LEN`, go to ERROR.
  - `code_valid` is ignored outside IDLE.
- ERROR: `err`=1, `bit_ready`=0; held until reset.
- DONE: `done`=1, `bit_ready`=0; held until reset.
- `sym` holds its last value between pulses.

## Timing
- Reset values: `bit_ready`=0, `sym_valid`=0, `sym`=0, `done`=0, `err`=0, all CNTx=0. State IDLE; `acc`, `len` and the symbol counter are 0.
- Table load: `code_valid` sampled in cycle t; `bit_ready`=1 from cycle t+1.
- Symbol latency: last bit of a codeword accepted at edge t, so `sym_valid`/`sym` are visible after edge t and last one cycle.
- Throughput: one bit per cycle; a 1-bit code yields one symbol per cycle.
- Back-to-back: the bit accepted in the same cycle `sym_valid` is high belongs to the next codeword.
- Boundary, last symbol:
  - `done` and the final `sym_valid` rise in the same cycle.
  - `bit_ready` drops that cycle, so no further bit is accepted.
- Boundary, error: `err` rises one cycle after the `MAX_LEN`-th unmatched bit. No `sym_valid` is issued for that bit.
- `bit_valid`=0: no state change.
- Reset mid-decode: after the first edge with `reset`=0, every output takes its reset value and the table must be reloaded.

## Configuration
- `HUFF_DEC_HIST_EN` defined:
  - CNT1..CNT6 ports exist.
  - CNTk increments (8-bit, saturating at 255) in the cycle `sym_valid` is asserted with `sym`==k.
  - Counts are cleared only by reset.
  - After a matched encode/decode round trip they equal the encoder's CNT outputs.
- Not defined: CNT ports and counters are absent; all other behaviour is identical.

## Test plan
- **Table T:** HC/M = 00/01, 02/03, 06/07, 0E/0F, 1E/1F, 1F/1F.
- **Load and 2-bit code:** load T, send 1,0 → `sym_valid` one cycle after the second bit, `sym`=2; `bit_ready` stays 1.
- **Back-to-back 1-bit codes:** send 0,0,0 → three consecutive `sym_valid` pulses, `sym`=1 each.
- **Error:** load T with M6=00, send 1,1,1,1,1,1,1,1 → no `sym_valid`; `err`=1 one cycle after the 8th bit; `bit_ready`=0 and held.
- **Done:** `NUM_SYMS`=100, send 100 codewords mixing all six symbols → `done` with the 100th `sym_valid`; further `bit_valid` is ignored. With `HUFF_DEC_HIST_EN`, CNT1..6 match the symbols sent.
- **Reset mid-stream:** `reset`=0 for one cycle after 37 symbols → all outputs 0, state IDLE; after reload, decoding restarts and the symbol count starts from 0.

Source files
------------

// File: rtl/huffman_decoder_if.sv
// Bit-stream / symbol handshake bundle for huffman_decoder.
// The master drives stream bits and the slave (decoder) returns ready and decoded symbols.
interface huffman_decoder_if;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_ready;
  logic       sym_valid;
  logic [2:0] sym;

  modport master (output bit_valid, output bit_in,
                  input  bit_ready, input sym_valid, input sym);
  modport slave  (input  bit_valid, input bit_in,
                  output bit_ready, output sym_valid, output sym);
endinterface

// File: rtl/huffman_decoder.sv
// Bit-serial decoder for the six-entry grey-level Huffman table (symbols 1..6).
// Define HUFF_DEC_HIST_EN to add the saturating per-symbol counters CNT1..CNT6.
module huffman_decoder #(
  parameter int NUM_SYMS = 100,
  parameter int MAX_LEN  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  input  logic [7:0]       HC1,
  input  logic [7:0]       HC2,
  input  logic [7:0]       HC3,
  input  logic [7:0]       HC4,
  input  logic [7:0]       HC5,
  input  logic [7:0]       HC6,
  input  logic [7:0]       M1,
  input  logic [7:0]       M2,
  input  logic [7:0]       M3,
  input  logic [7:0]       M4,
  input  logic [7:0]       M5,
  input  logic [7:0]       M6,
  huffman_decoder_if.slave stream,
  output logic             done,
  output logic             err
`ifdef HUFF_DEC_HIST_EN
  ,
  output logic [7:0]       CNT1,
  output logic [7:0]       CNT2,
  output logic [7:0]       CNT3,
  output logic [7:0]       CNT4,
  output logic [7:0]       CNT5,
  output logic [7:0]       CNT6
`endif
);

  localparam logic [7:0] NUM_SYMS_L = 8'(NUM_SYMS);
  localparam logic [3:0] MAX_LEN_L  = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_DECODE = 2'd1,
    STATE_ERROR  = 2'd2,
    STATE_DONE   = 2'd3
  } state_e;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  state_e     state_q, state_d;
  logic [7:0] hc_q [6];
  logic [7:0] hc_d [6];
  logic [7:0] m_q  [6];
  logic [7:0] m_d  [6];
  logic [3:0] ln_q [6];
  logic [3:0] ln_d [6];
  logic [7:0] acc_q, acc_d;
  logic [3:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] sym_q, sym_d;
  logic       sym_valid_q, sym_valid_d;
  logic       bit_ready_q, bit_ready_d;
  logic       done_q, done_d;
  logic       err_q, err_d;

  logic [7:0] new_acc;
  logic [3:0] new_len;
  logic [5:0] match_v;
  logic [2:0] hit_idx;
  logic       accept;
  logic       hit;

  assign new_acc = {acc_q[6:0], stream.bit_in};
  assign new_len = len_q + 4'd1;
  assign accept  = stream.bit_valid && bit_ready_q;
  assign hit     = |match_v;

  // Table match against the post-shift accumulator; lowest-index entry wins.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      match_v[k] = (m_q[k] != 8'h00) && (ln_q[k] == new_len) &&
                   ((new_acc & m_q[k]) == hc_q[k]);
    end
    casez (match_v)
      6'b?????1: hit_idx = 3'd1;
      6'b????10: hit_idx = 3'd2;
      6'b???100: hit_idx = 3'd3;
      6'b??1000: hit_idx = 3'd4;
      6'b?10000: hit_idx = 3'd5;
      6'b100000: hit_idx = 3'd6;
      default:   hit_idx = 3'd0;
    endcase
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    hc_d        = hc_q;
    m_d         = m_q;
    ln_d        = ln_q;
    acc_d       = acc_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    sym_d       = sym_q;
    sym_valid_d = 1'b0;
    case (state_q)
      STATE_IDLE: begin
        if (code_valid) begin
          hc_d[0] = HC1; hc_d[1] = HC2; hc_d[2] = HC3;
          hc_d[3] = HC4; hc_d[4] = HC5; hc_d[5] = HC6;
          m_d[0]  = M1;  m_d[1]  = M2;  m_d[2]  = M3;
          m_d[3]  = M4;  m_d[4]  = M5;  m_d[5]  = M6;
          for (int k = 0; k < 6; k++) begin
            ln_d[k] = popcount8(m_d[k]);
          end
          state_d = STATE_DECODE;
        end else begin
          state_d = STATE_IDLE;
        end
      end
      STATE_DECODE: begin
        if (accept) begin
          acc_d = new_acc;
          len_d = new_len;
          if (hit) begin
            sym_d       = hit_idx;
            sym_valid_d = 1'b1;
            acc_d       = 8'h00;
            len_d       = 4'd0;
            cnt_d       = cnt_q + 8'd1;
            state_d     = (cnt_d == NUM_SYMS_L) ? STATE_DONE : STATE_DECODE;
          end else if (new_len == MAX_LEN_L) begin
            state_d = STATE_ERROR;
          end else begin
            state_d = STATE_DECODE;
          end
        end else begin
          state_d = STATE_DECODE;
        end
      end
      STATE_ERROR: state_d = STATE_ERROR;
      STATE_DONE:  state_d = STATE_DONE;
      default:     state_d = STATE_IDLE;
    endcase
    bit_ready_d = (state_d == STATE_DECODE);
    done_d      = (state_d == STATE_DONE);
    err_d       = (state_d == STATE_ERROR);
  end

  // State, table and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= STATE_IDLE;
      hc_q        <= '{default: 8'h00};
      m_q         <= '{default: 8'h00};
      ln_q        <= '{default: 4'd0};
      acc_q       <= 8'h00;
      len_q       <= 4'd0;
      cnt_q       <= 8'h00;
      sym_q       <= 3'd0;
      sym_valid_q <= 1'b0;
      bit_ready_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      m_q         <= m_d;
      ln_q        <= ln_d;
      acc_q       <= acc_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      bit_ready_q <= bit_ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign stream.bit_ready = bit_ready_q;
  assign stream.sym_valid = sym_valid_q;
  assign stream.sym       = sym_q;
  assign done             = done_q;
  assign err              = err_q;

`ifdef HUFF_DEC_HIST_EN
  logic [7:0] hist_q [6];
  logic [7:0] hist_d [6];

  // Saturating per-symbol counters, bumped alongside the matching sym_valid pulse.
  always_comb begin
    for (int k = 0; k < 6; k++) begin
      hist_d[k] = hist_q[k] + {7'd0, (state_q == STATE_DECODE) && accept && hit &&
                                     (hit_idx == 3'(k + 1)) && (hist_q[k] != 8'hFF)};
    end
  end

  // Histogram registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist_q <= '{default: 8'h00};
    end else begin
      hist_q <= hist_d;
    end
  end

  assign CNT1 = hist_q[0];
  assign CNT2 = hist_q[1];
  assign CNT3 = hist_q[2];
  assign CNT4 = hist_q[3];
  assign CNT5 = hist_q[4];
  assign CNT6 = hist_q[5];
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Self-checking bench for huffman_decoder: scoreboard of expected symbols plus per-scenario tasks.
// Histogram checks are compiled in when HUFF_DEC_HIST_EN is defined.
module tb_huffman_decoder;

  localparam int NUM = 100;

  logic       clk;
  logic       reset;
  logic       code_valid;
  logic [7:0] tab_hc [6];
  logic [7:0] tab_m  [6];
  logic       done;
  logic       err;
  int         checks;
  int         failures;
  logic [2:0] exp_q [$];
  int         exp_cnt [6];

  huffman_decoder_if dif ();

`ifdef HUFF_DEC_HIST_EN
  logic [7:0] cnt [6];
`endif

  huffman_decoder #(.NUM_SYMS(NUM), .MAX_LEN(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .HC1        (tab_hc[0]),
    .HC2        (tab_hc[1]),
    .HC3        (tab_hc[2]),
    .HC4        (tab_hc[3]),
    .HC5        (tab_hc[4]),
    .HC6        (tab_hc[5]),
    .M1         (tab_m[0]),
    .M2         (tab_m[1]),
    .M3         (tab_m[2]),
    .M4         (tab_m[3]),
    .M5         (tab_m[4]),
    .M6         (tab_m[5]),
    .stream     (dif.slave),
    .done       (done),
    .err        (err)
`ifdef HUFF_DEC_HIST_EN
    ,
    .CNT1       (cnt[0]),
    .CNT2       (cnt[1]),
    .CNT3       (cnt[2]),
    .CNT4       (cnt[3]),
    .CNT5       (cnt[4]),
    .CNT6       (cnt[5])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every sym_valid pulse must match the oldest expected symbol.
  always @(negedge clk) begin
    if (dif.sym_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_unexpected got sym=%0d expected no symbol", dif.sym);
      end else begin
        logic [2:0] e;
        e = exp_q.pop_front();
        if (dif.sym !== e) begin
          failures++;
          $display("FAIL scoreboard_sym got=%0d expected=%0d", dif.sym, e);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout simulation exceeded time limit");
    $fatal(1);
  end

  function automatic int ones(input logic [7:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 8; i++) n += int'(v[i]);
    return n;
  endfunction

  task automatic set_table_t();
    tab_hc[0] = 8'h00; tab_m[0] = 8'h01;
    tab_hc[1] = 8'h02; tab_m[1] = 8'h03;
    tab_hc[2] = 8'h06; tab_m[2] = 8'h07;
    tab_hc[3] = 8'h0E; tab_m[3] = 8'h0F;
    tab_hc[4] = 8'h1E; tab_m[4] = 8'h1F;
    tab_hc[5] = 8'h1F; tab_m[5] = 8'h1F;
  endtask

  task automatic do_reset();
    reset         = 1'b0;
    code_valid    = 1'b0;
    dif.bit_valid = 1'b0;
    dif.bit_in    = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) exp_cnt[k] = 0;
  endtask

  task automatic load_table();
    checks++;
    if (dif.bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL idle_ready got=%b expected=0", dif.bit_ready);
    end
    code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0;
    checks++;
    if (dif.bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL load_ready got=%b expected=1", dif.bit_ready);
    end
  endtask

  task automatic send_code(input int k);
    int         n;
    logic [7:0] c;
    c = tab_hc[k-1];
    n = ones(tab_m[k-1]);
    for (int b = n - 1; b >= 0; b--) begin
      checks++;
      if (dif.bit_ready !== 1'b1) begin
        failures++;
        $display("FAIL send_ready sym=%0d got=%b expected=1", k, dif.bit_ready);
      end
      dif.bit_valid = 1'b1;
      dif.bit_in    = c[b];
      if (b == 0) begin
        exp_q.push_back(3'(k));
        exp_cnt[k-1]++;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_hist(input string tag);
`ifdef HUFF_DEC_HIST_EN
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (cnt[k] !== 8'(exp_cnt[k])) begin
        failures++;
        $display("FAIL hist_%s CNT%0d got=%0d expected=%0d", tag, k + 1, cnt[k], exp_cnt[k]);
      end
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic check_outputs_zero(input string tag);
    checks++;
    if ({dif.bit_ready, dif.sym_valid, dif.sym, done, err} !== 7'b0) begin
      failures++;
      $display("FAIL %s ready=%b sv=%b sym=%0d done=%b err=%b expected all 0",
               tag, dif.bit_ready, dif.sym_valid, dif.sym, done, err);
    end
  endtask

  task automatic test_reset();
    reset         = 1'b0;
    code_valid    = 1'b0;
    dif.bit_valid = 1'b0;
    dif.bit_in    = 1'b0;
    set_table_t();
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_outputs_zero("reset_outputs");
    check_hist("reset");
    reset = 1'b1;
  endtask

  task automatic test_two_bit();
    do_reset();
    set_table_t();
    load_table();
    send_code(2);
    dif.bit_valid = 1'b0;
    checks++;
    if (dif.sym_valid !== 1'b1 || dif.sym !== 3'd2 || dif.bit_ready !== 1'b1) begin
      failures++;
      $display("FAIL two_bit sv=%b sym=%0d ready=%b expected 1,2,1",
               dif.sym_valid, dif.sym, dif.bit_ready);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      send_code(1);
      checks++;
      if (dif.sym_valid !== 1'b1 || dif.sym !== 3'd1) begin
        failures++;
        $display("FAIL back_to_back[%0d] sv=%b sym=%0d expected 1,1", i, dif.sym_valid, dif.sym);
      end
    end
    dif.bit_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (dif.sym_valid !== 1'b0 || dif.sym !== 3'd1) begin
      failures++;
      $display("FAIL sym_hold sv=%b sym=%0d expected 0,1", dif.sym_valid, dif.sym);
    end
  endtask

  task automatic test_error();
    do_reset();
    set_table_t();
    tab_m[5] = 8'h00;
    load_table();
    for (int i = 0; i < 8; i++) begin
      dif.bit_valid = 1'b1;
      dif.bit_in    = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (err !== (i == 7) || dif.sym_valid !== 1'b0) begin
        failures++;
        $display("FAIL error_bit[%0d] err=%b sv=%b expected err=%0d sv=0", i, err, dif.sym_valid, i == 7);
      end
    end
    for (int i = 0; i < 4; i++) begin
      dif.bit_in = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (err !== 1'b1 || dif.bit_ready !== 1'b0 || dif.sym_valid !== 1'b0) begin
        failures++;
        $display("FAIL error_hold err=%b ready=%b sv=%b expected 1,0,0", err, dif.bit_ready, dif.sym_valid);
      end
    end
    dif.bit_valid = 1'b0;
  endtask

  task automatic test_done();
    do_reset();
    set_table_t();
    load_table();
    for (int i = 0; i < NUM; i++) begin
      send_code(((i * 5) % 6) + 1);
      if (i == NUM - 2) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL done_early got=%b expected=0", done);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || dif.sym_valid !== 1'b1 || dif.bit_ready !== 1'b0) begin
      failures++;
      $display("FAIL done_edge done=%b sv=%b ready=%b expected 1,1,0", done, dif.sym_valid, dif.bit_ready);
    end
    dif.bit_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || dif.bit_ready !== 1'b0 || dif.sym_valid !== 1'b0 || err !== 1'b0) begin
        failures++;
        $display("FAIL done_hold done=%b ready=%b sv=%b err=%b expected 1,0,0,0",
                 done, dif.bit_ready, dif.sym_valid, err);
      end
    end
    dif.bit_valid = 1'b0;
    check_hist("done");
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_table_t();
    load_table();
    for (int i = 0; i < 37; i++) send_code(((i + 3) % 6) + 1);
    dif.bit_valid = 1'b0;
    reset         = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int k = 0; k < 6; k++) exp_cnt[k] = 0;
    check_outputs_zero("midreset_outputs");
    check_hist("midreset");
    dif.bit_valid = 1'b1;
    dif.bit_in    = 1'b0;
    @(posedge clk); #1;
    dif.bit_valid = 1'b0;
    check_outputs_zero("midreset_idle");
    load_table();
    for (int i = 0; i < NUM - 1; i++) send_code(((i + 1) % 6) + 1);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL restart_count done=%b expected=0 after %0d symbols", done, NUM - 1);
    end
    send_code(4);
    dif.bit_valid = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL restart_done got=%b expected=1", done);
    end
    check_hist("restart");
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_two_bit();
    test_back_to_back();
    test_error();
    test_done();
    test_reset_mid();
    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
